sort_unit_arbiter: RTL and testbench

//  Shares one pipelined 4-element sort unit (fixed 3-cycle latency, no backpressure)

---
 rtl/sort_arb_pkg.sv | 29 ++
 rtl/sort_arb_resp_fifo.sv | 61 ++++++
 rtl/sort_unit_arbiter.sv | 151 +++++++++++++++
 tb/tb_sort_unit_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_arb_pkg.sv
// sort_arb_pkg: shared constants and types for the sort-unit arbiter.
//   SORT_LAT   - fixed latency of the shared sort unit (issue -> result valid)
//   SORT_N     - elements per sort message
//   id_width() - clog2 with a floor of 1 bit, for ids, pointers and counters
//   req_id_t   - requester id carried down the tag pipe (sized for MAX_REQ)
//   sort_msg_t - 4-element message, elm0 in the LSBs (default element width)
package sort_arb_pkg;

  localparam int SORT_LAT = 3;
  localparam int SORT_N   = 4;
  localparam int MAX_REQ  = 4;
  localparam int ELM_W    = 8;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = id_width(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic [ELM_W-1:0] e3;
    logic [ELM_W-1:0] e2;
    logic [ELM_W-1:0] e1;
    logic [ELM_W-1:0] e0;
  } sort_msg_t;

endpackage

// File: rtl/sort_arb_resp_fifo.sv
// sort_arb_resp_fifo: p_depth-entry synchronous FIFO holding sorted results
// for one requester. No bypass: a push is visible at the head the next cycle.
// The upstream credit scheme guarantees a push never lands on a full FIFO,
// so there is no enqueue ready.
//   clk, reset  clock, synchronous active-low reset (empties the FIFO)
//   enq_val_i   push strobe
//   enq_msg_i   data to push
//   deq_rdy_i   consumer ready; a pop happens when deq_val_o && deq_rdy_i
//   deq_val_o   FIFO non-empty
//   deq_msg_o   head entry (don't-care when empty)
module sort_arb_resp_fifo
  import sort_arb_pkg::*;
#(
  parameter int p_width = 32,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val_i,
  input  logic [p_width-1:0] enq_msg_i,
  input  logic               deq_rdy_i,
  output logic               deq_val_o,
  output logic [p_width-1:0] deq_msg_o
);

  localparam int PW = id_width(p_depth);
  localparam int CW = id_width(p_depth + 1);

  logic [p_depth-1:0][p_width-1:0] mem_q;
  logic [PW-1:0]                   rd_q, wr_q;
  logic [CW-1:0]                   cnt_q;
  logic                            deq;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign deq_val_o = (cnt_q != '0);
  assign deq_msg_o = mem_q[rd_q];
  assign deq       = deq_val_o & deq_rdy_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq_val_i) begin
        mem_q[wr_q] <= enq_msg_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (deq) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(enq_val_i) - CW'(deq);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(enq_val_i && cnt_q == CW'(p_depth)));

endmodule

// File: rtl/sort_unit_arbiter.sv
// sort_unit_arbiter: shares one pipelined 4-element sort unit among p_nreq
// requesters. Round-robin grant, one issue per cycle, each issue tagged with
// its requester id; results are steered into per-requester response FIFOs.
// Per-requester credits (free FIFO slots minus in-flight sorts) guarantee a
// returning result always has room.
//   clk, reset          clock, synchronous active-low reset
//   req_val/rdy/msg     per-requester request channel, 4 elements each
//   resp_val/rdy/msg    per-requester sorted response channel
//   su_reset            active-high reset to the sort unit
//   su_in_val, su_in    issue to the sort unit
//   su_out_val, su_out  result from the sort unit, SORT_LAT cycles after issue
module sort_unit_arbiter
  import sort_arb_pkg::*;
#(
  parameter int p_nbits = 8,
  parameter int p_nreq  = 2,
  parameter int p_depth = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [p_nreq-1:0]           req_val,
  output logic [p_nreq-1:0]           req_rdy,
  input  logic [p_nreq*4*p_nbits-1:0] req_msg,
  output logic [p_nreq-1:0]           resp_val,
  input  logic [p_nreq-1:0]           resp_rdy,
  output logic [p_nreq*4*p_nbits-1:0] resp_msg,
  output logic                        su_reset,
  output logic                        su_in_val,
  output logic [4*p_nbits-1:0]        su_in,
  input  logic                        su_out_val,
  input  logic [4*p_nbits-1:0]        su_out
);

  localparam int MW = SORT_N * p_nbits;
  localparam int CW = id_width(p_depth + 1);

  logic [p_nreq-1:0][MW-1:0] req_msg_a, resp_msg_a;
  logic [p_nreq-1:0][CW-1:0] credits_q, credits_d;
  logic [p_nreq-1:0]         elig, gnt, fire, pop, fifo_val;
  logic                      gnt_any, fire_any;
  req_id_t                   gnt_id, rr_q, rr_d;
  int                        idx;

  // Tag pipe: entry 0 is the issue itself, entry SORT_LAT lines up with su_out_val.
  logic    [SORT_LAT:0] vld_pipe;
  logic    [SORT_LAT:1] vld_q;
  req_id_t [SORT_LAT:0] id_pipe;
  req_id_t [SORT_LAT:1] id_q;

  assign req_msg_a = req_msg;
  assign resp_msg  = resp_msg_a;
  assign su_reset  = ~reset;

  // ---- Round-robin grant: first eligible at or after rr_q, with wrap ----
  always_comb begin
    for (int i = 0; i < p_nreq; i++) elig[i] = req_val[i] && (credits_q[i] != '0);
  end

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < p_nreq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= p_nreq) idx = idx - p_nreq;
      if (!gnt_any && elig[idx]) begin
        gnt_any  = 1'b1;
        gnt_id   = req_id_t'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  // Grant only depends on req_val and credits, never on resp_rdy.
  assign req_rdy   = gnt & {p_nreq{reset}};
  assign fire      = req_val & req_rdy;
  assign fire_any  = |fire;
  assign su_in_val = fire_any;

  always_comb begin
    su_in = '0;
    for (int i = 0; i < p_nreq; i++) if (gnt[i]) su_in = req_msg_a[i];
  end

  always_comb begin
    rr_d = rr_q;
    if (fire_any) rr_d = (gnt_id == req_id_t'(p_nreq - 1)) ? '0 : gnt_id + 1'b1;
  end

  // ---- Credits: same-cycle issue and pop cancel ----
  assign resp_val = fifo_val & {p_nreq{reset}};
  assign pop      = resp_val & resp_rdy;

  always_comb begin
    for (int i = 0; i < p_nreq; i++) begin
      credits_d[i] = credits_q[i];
      case ({fire[i], pop[i]})
        2'b10:   credits_d[i] = credits_q[i] - 1'b1;
        2'b01:   credits_d[i] = credits_q[i] + 1'b1;
        default: ;
      endcase
    end
  end

  // ---- Tag pipe ----
  assign vld_pipe = {vld_q, fire_any};
  assign id_pipe  = {id_q, gnt_id};

  always_ff @(posedge clk) begin
    if (!reset) begin
      credits_q <= {p_nreq{CW'(p_depth)}};
      rr_q      <= '0;
      vld_q     <= '0;
    end else begin
      credits_q <= credits_d;
      rr_q      <= rr_d;
      vld_q     <= vld_pipe[SORT_LAT-1:0];
    end
  end

  // Ids are only meaningful alongside their valid bit, so no reset needed.
  always_ff @(posedge clk) id_q <= id_pipe[SORT_LAT-1:0];

  // The tag valid, not su_out_val, decides whether a result is kept; this is
  // what drops stale sort-unit results after a mid-flight reset.
  a_tag_align: assert property (@(posedge clk) disable iff (!reset)
    vld_pipe[SORT_LAT] == su_out_val);

  // ---- Per-requester lanes ----
  for (genvar i = 0; i < p_nreq; i++) begin : g_lane
    logic push;
    assign push = vld_pipe[SORT_LAT] && (id_pipe[SORT_LAT] == req_id_t'(i));

    sort_arb_resp_fifo #(.p_width(MW), .p_depth(p_depth)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enq_val_i (push),
      .enq_msg_i (su_out),
      .deq_rdy_i (resp_rdy[i]),
      .deq_val_o (fifo_val[i]),
      .deq_msg_o (resp_msg_a[i])
    );

    a_credit_under: assert property (@(posedge clk) disable iff (!reset)
      !(fire[i] && !pop[i] && credits_q[i] == '0));
    a_credit_over: assert property (@(posedge clk) disable iff (!reset)
      !(pop[i] && !fire[i] && credits_q[i] == CW'(p_depth)));
  end

endmodule

// File: tb/tb_sort_unit_arbiter.sv
// Self-checking bench for sort_unit_arbiter with a behavioural 3-cycle sort
// unit. Expected results are pushed per requester at issue and popped and
// compared when the DUT delivers a response.
module tb_sort_unit_arbiter;
  import sort_arb_pkg::*;

  localparam int NB = 8, NREQ = 2, DEPTH = 4, W = 4 * NB;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_val, req_rdy, resp_val, resp_rdy;
  logic [NREQ*W-1:0]    req_msg, resp_msg;
  logic                 su_reset, su_in_val, su_out_val;
  logic [W-1:0]         su_in, su_out;

  int n_tests = 0, n_fail = 0;
  int resp_cnt [NREQ];
  logic [W-1:0] exp_q [NREQ][$];

  always #5 clk = ~clk;

  sort_unit_arbiter #(.p_nbits(NB), .p_nreq(NREQ), .p_depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .su_reset(su_reset), .su_in_val(su_in_val), .su_in(su_in),
    .su_out_val(su_out_val), .su_out(su_out)
  );

  function automatic logic [W-1:0] sort4(input logic [W-1:0] m);
    logic [3:0][NB-1:0] a;
    logic [NB-1:0] t;
    a = m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a;
  endfunction

  // Behavioural sort unit: fixed 3-cycle latency, synchronous active-high reset.
  logic [2:0]        sv;
  logic [2:0][W-1:0] sd;
  always @(posedge clk) begin
    if (su_reset) sv <= '0;
    else begin
      sv <= {sv[1:0], su_in_val};
      sd <= {sd[1:0], sort4(su_in)};
    end
  end
  assign su_out_val = sv[2];
  assign su_out     = sd[2];

  // Scoreboard monitor: samples mid-cycle after the drivers have settled.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      n_tests++;
      if (su_in_val !== |(req_val & req_rdy) || $countones(req_rdy) > 1) begin
        n_fail++;
        $display("FAIL issue_strobe: su_in_val=%b req_rdy=%b req_val=%b", su_in_val, req_rdy, req_val);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_val[i] && req_rdy[i]) begin
          n_tests++;
          if (su_in !== req_msg[i*W +: W]) begin
            n_fail++;
            $display("FAIL su_in[%0d]: got %h want %h", i, su_in, req_msg[i*W +: W]);
          end
          exp_q[i].push_back(sort4(req_msg[i*W +: W]));
        end
        if (resp_val[i] && resp_rdy[i]) begin
          n_tests++;
          resp_cnt[i]++;
          if (exp_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected[%0d]: got %h want none", i, resp_msg[i*W +: W]);
          end else begin
            logic [W-1:0] e;
            e = exp_q[i].pop_front();
            if (resp_msg[i*W +: W] !== e) begin
              n_fail++;
              $display("FAIL resp_data[%0d]: got %h want %h", i, resp_msg[i*W +: W], e);
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_val = '0;
    #3;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; req_val = 2'b11; resp_rdy = 2'b11;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_tests++;
      if (req_rdy !== 2'b00 || resp_val !== 2'b00 || su_in_val !== 1'b0 || su_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_outputs: req_rdy=%b resp_val=%b su_in_val=%b su_reset=%b want 00 00 0 1",
                 req_rdy, resp_val, su_in_val, su_reset);
      end
    end
    @(negedge clk);
    reset = 1'b1; req_val = '0;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      n_tests++;
      if (dut.credits_q[i] !== 3'd4) begin
        n_fail++;
        $display("FAIL reset_credits[%0d]: got %0d want 4", i, dut.credits_q[i]);
      end
    end
  endtask

  task automatic test_single();
    sort_msg_t m, e;
    m = '{e3: 8'd2, e2: 8'd4, e1: 8'd1, e0: 8'd3};
    e = '{e3: 8'd4, e2: 8'd3, e1: 8'd2, e0: 8'd1};
    @(negedge clk);
    resp_rdy = 2'b11; req_val = 2'b01; req_msg[W-1:0] = m;
    #1;
    n_tests++;
    if (req_rdy !== 2'b01 || su_in_val !== 1'b1 || su_in !== W'(m)) begin
      n_fail++;
      $display("FAIL single_issue: req_rdy=%b su_in_val=%b su_in=%h want 01 1 %h", req_rdy, su_in_val, su_in, m);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_val = '0;
      #1;
      n_tests++;
      if (k == 4) begin
        if (resp_val !== 2'b01 || resp_msg[W-1:0] !== W'(e)) begin
          n_fail++;
          $display("FAIL single_resp: resp_val=%b msg=%h want 01 %h", resp_val, resp_msg[W-1:0], e);
        end
      end else if (resp_val !== 2'b00) begin
        n_fail++;
        $display("FAIL single_latency[c%0d]: resp_val=%b want 00", k, resp_val);
      end
    end
  endtask

  task automatic test_alternate();
    int c0, c1;
    do_reset();
    c0 = resp_cnt[0]; c1 = resp_cnt[1];
    resp_rdy = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_val = 2'b11; req_msg = {$urandom, $urandom};
      #1;
      n_tests++;
      if (req_rdy !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL alt_grant[c%0d]: req_rdy=%b want %b", c, req_rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    @(negedge clk);
    req_val = '0;
    cyc(8);
    n_tests++;
    if (resp_cnt[0] - c0 != 3 || resp_cnt[1] - c1 != 3 || exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      n_fail++;
      $display("FAIL alt_counts: got %0d/%0d pending %0d/%0d want 3/3 pending 0/0",
               resp_cnt[0] - c0, resp_cnt[1] - c1, exp_q[0].size(), exp_q[1].size());
    end
  endtask

  task automatic test_credit_full();
    int issues;
    do_reset();
    resp_rdy = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_val = 2'b10; req_msg = {$urandom, $urandom};
      #1;
      n_tests++;
      if (req_rdy !== 2'b10) begin
        n_fail++;
        $display("FAIL full_fill[c%0d]: req_rdy=%b want 10", c, req_rdy);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_val = 2'b11; req_msg = {$urandom, $urandom};
      #1;
      n_tests++;
      if (req_rdy !== 2'b01 || dut.credits_q[1] !== 3'd0) begin
        n_fail++;
        $display("FAIL full_other[c%0d]: req_rdy=%b credits1=%0d want 01 0", c, req_rdy, dut.credits_q[1]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_val = 2'b10;
      #1;
      n_tests++;
      if (req_rdy !== 2'b00) begin
        n_fail++;
        $display("FAIL full_block[c%0d]: req_rdy=%b want 00", c, req_rdy);
      end
    end
    @(negedge clk);
    resp_rdy = 2'b11;
    #1;
    n_tests++;
    if (req_rdy !== 2'b00) begin
      n_fail++;
      $display("FAIL full_pop_cycle: req_rdy=%b want 00", req_rdy);
    end
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      resp_rdy = 2'b01; req_msg = {$urandom, $urandom};
      #1;
      if (req_rdy[1]) issues++;
    end
    n_tests++;
    if (issues != 1) begin
      n_fail++;
      $display("FAIL full_one_credit: issues=%0d want 1", issues);
    end
    @(negedge clk);
    req_val = '0; resp_rdy = 2'b11;
    cyc(10);
    n_tests++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || dut.credits_q[1] !== 3'd4) begin
      n_fail++;
      $display("FAIL full_drain: pending %0d/%0d credits1=%0d want 0/0 4",
               exp_q[0].size(), exp_q[1].size(), dut.credits_q[1]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    resp_rdy = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_val = 2'b01; req_msg = {$urandom, $urandom};
    end
    @(negedge clk);
    req_val = '0;
    cyc(5);
    #1;
    n_tests++;
    if (dut.credits_q[0] !== 3'd1 || resp_val[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL same_setup: credits0=%0d resp_val0=%b want 1 1", dut.credits_q[0], resp_val[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_val = (c < 2) ? 2'b01 : 2'b00; resp_rdy = (c < 2) ? 2'b01 : 2'b11;
      req_msg = {$urandom, $urandom};
      #1;
      n_tests++;
      if (dut.credits_q[0] !== 3'd1 || (c < 2 && req_rdy !== 2'b01)) begin
        n_fail++;
        $display("FAIL same_cycle[c%0d]: credits0=%0d req_rdy=%b want 1 01", c, dut.credits_q[0], req_rdy);
      end
    end
    cyc(10);
    n_tests++;
    if (exp_q[0].size() != 0 || dut.credits_q[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL same_drain: pending=%0d credits0=%0d want 0 4", exp_q[0].size(), dut.credits_q[0]);
    end
  endtask

  task automatic test_reset_midflight();
    int c1;
    resp_rdy = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_val = 2'b01; req_msg = {$urandom, $urandom};
    end
    do_reset();
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++;
      if (resp_val !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_resp[c%0d]: resp_val=%b want 00", c, resp_val);
      end
      @(negedge clk);
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      n_tests++;
      if (dut.credits_q[i] !== 3'd4) begin
        n_fail++;
        $display("FAIL midreset_credits[%0d]: got %0d want 4", i, dut.credits_q[i]);
      end
    end
    c1 = resp_cnt[1];
    @(negedge clk);
    req_val = 2'b10; req_msg = {$urandom, $urandom};
    @(negedge clk);
    req_val = '0;
    cyc(6);
    n_tests++;
    if (resp_cnt[1] - c1 != 1 || exp_q[1].size() != 0) begin
      n_fail++;
      $display("FAIL midreset_fresh: responses=%0d pending=%0d want 1 0", resp_cnt[1] - c1, exp_q[1].size());
    end
  endtask

  initial begin
    reset = 1'b0; req_val = '0; resp_rdy = '0; req_msg = '0;
    for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
    test_reset();
    test_single();
    test_alternate();
    test_credit_full();
    test_same_cycle();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
